adder_share_scheduler: RTL and testbench

//  Shares one clocked 32-bit add-with-carry datapath between NUM_REQ requesters.

---
 rtl/adder_sched_pkg.sv | 22 ++
 rtl/adder_core.sv | 27 ++
 rtl/adder_share_scheduler.sv | 158 +++++++++++++++
 tb/tb_adder_share_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_sched_pkg.sv
// Shared state encoding, sizing helper and default dimensions for the adder-sharing scheduler.
package adder_sched_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_ADD_LAT = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Bits needed to encode n distinct values, never less than one.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/adder_core.sv
// Shared add-with-carry datapath: {carry, sum} = a + b + cin, ADD_LAT register stages deep.
module adder_core #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic             clock,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0]                raw;
  logic [ADD_LAT-1:0][WIDTH:0]   stage;

  assign raw = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);

  if (ADD_LAT == 1) begin : g_one
    always_ff @(posedge clock) stage[0] <= raw;
  end else begin : g_multi
    always_ff @(posedge clock) stage <= {stage[ADD_LAT-2:0], raw};
  end

  assign {carry, sum} = stage[ADD_LAT-1];

endmodule

// File: rtl/adder_share_scheduler.sv
// Arbitrates NUM_REQ requesters onto one adder_core and returns tagged {sum, carry} over valid/ready.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module adder_share_scheduler
  import adder_sched_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ADD_LAT = DEF_ADD_LAT
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]    req_a,
  input  logic [NUM_REQ*WIDTH-1:0]    req_b,
  input  logic [NUM_REQ-1:0]          req_cin,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [clog2(NUM_REQ)-1:0]   resp_id,
  output logic [WIDTH-1:0]            resp_sum,
  output logic                        resp_carry
);

  localparam int unsigned ID_W  = clog2(NUM_REQ);
  localparam int unsigned CNT_W = clog2(ADD_LAT + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a, op_b, op_a_nxt, op_b_nxt;
  logic             op_cin, op_cin_nxt;
  logic [ID_W-1:0]  op_id;
  logic [WIDTH-1:0] core_sum;
  logic             core_carry;
  logic             gnt_found;
  logic [ID_W-1:0]  gnt_idx;
  logic             load, capture;

  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
    assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;

  // Search starts just after the last winner so every requester gets a turn.
  function automatic logic [ID_W:0] arbitrate(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] res;
    int unsigned   j;
    res = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      j = (32'(ptr) + k) % NUM_REQ;
      if (!res[ID_W] && valid[ID_W'(j)]) res = {1'b1, ID_W'(j)};
    end
    return res;
  endfunction

  assign {gnt_found, gnt_idx} = arbitrate(req_valid, rr_ptr);

  always_ff @(posedge clock) begin
    if (reset)     rr_ptr <= ID_W'(NUM_REQ - 1);
    else if (load) rr_ptr <= gnt_idx;
  end
`else
  function automatic logic [ID_W:0] arbitrate(input logic [NUM_REQ-1:0] valid);
    logic [ID_W:0] res;
    res = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!res[ID_W] && valid[ID_W'(k)]) res = {1'b1, ID_W'(k)};
    end
    return res;
  endfunction

  assign {gnt_found, gnt_idx} = arbitrate(req_valid);
`endif

  // Next-state and grant decode.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    load      = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          load               = 1'b1;
          state_nxt          = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt == CNT_W'(ADD_LAT - 1)) begin
          capture   = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  assign op_a_nxt   = load ? a_arr[gnt_idx]   : op_a;
  assign op_b_nxt   = load ? b_arr[gnt_idx]   : op_b;
  assign op_cin_nxt = load ? req_cin[gnt_idx] : op_cin;

  // Core samples the operand-register D side so its first stage lines up with the operand registers.
  adder_core #(
    .WIDTH   (WIDTH),
    .ADD_LAT (ADD_LAT)
  ) u_core (
    .clock (clock),
    .a     (op_a_nxt),
    .b     (op_b_nxt),
    .cin   (op_cin_nxt),
    .sum   (core_sum),
    .carry (core_carry)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_cin     <= 1'b0;
      op_id      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_sum   <= '0;
      resp_carry <= 1'b0;
    end else begin
      op_a   <= op_a_nxt;
      op_b   <= op_b_nxt;
      op_cin <= op_cin_nxt;
      if (load) op_id <= gnt_idx;
      cnt <= (state == S_BUSY) ? cnt + 1'b1 : '0;
      if (capture) begin
        resp_valid <= 1'b1;
        resp_id    <= op_id;
        resp_sum   <= core_sum;
        resp_carry <= core_carry;
      end else if (state == S_RESP && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_share_scheduler.sv
// Scoreboard bench for adder_share_scheduler at default dimensions; follows ARB_ROUND_ROBIN_EN.
module tb_adder_share_scheduler;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADD_LAT = 1;
  localparam int unsigned LIMIT   = 3000;

  typedef struct { logic [31:0] a; logic [31:0] b; logic cin; } op_t;
  typedef struct { logic [1:0] id; logic [31:0] sum; logic carry; } rsp_t;

  logic                     clock;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_cin;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [1:0]               resp_id;
  logic [31:0]              resp_sum;
  logic                     resp_carry;

  adder_share_scheduler #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ),
    .ADD_LAT (ADD_LAT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_carry (resp_carry)
  );

  op_t              pq [NUM_REQ][$];
  op_t              cur [NUM_REQ];
  rsp_t             sb [$];
  int unsigned      n_chk = 0;
  int unsigned      n_fail = 0;
  int unsigned      cyc = 0;
  int unsigned      acc_cyc = 0;
  logic             busy = 1'b0;
  logic [NUM_REQ-1:0] acc_mask = '0;
  logic             hold_resp = 1'b0;
  logic             rnd_resp = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
  int               last_gnt = NUM_REQ - 1;
`endif

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference arbitration: which waiting requester should be served next.
`ifdef ARB_ROUND_ROBIN_EN
  function automatic int pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++)
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction
`else
  function automatic int pick(input logic [NUM_REQ-1:0] v);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[k]) return k;
    return -1;
  endfunction
`endif

  function automatic rsp_t model(input int id, input op_t o);
    logic [63:0] s;
    rsp_t        r;
    s       = 64'(o.a) + 64'(o.b) + 64'(o.cin);
    r.id    = 2'(id);
    r.sum   = s[31:0];
    r.carry = s[32];
    return r;
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic cin);
    op_t o;
    o.a = a; o.b = b; o.cin = cin;
    return o;
  endfunction

  function automatic logic pending();
    for (int i = 0; i < NUM_REQ; i++)
      if (pq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Requester driver: present the next queued operation once the current one is taken.
  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_mask[i] || !req_valid[i]) begin
          if (pq[i].size() != 0) begin
            cur[i]                  = pq[i].pop_front();
            req_valid[i]            = 1'b1;
            req_a[i*WIDTH +: WIDTH] = cur[i].a;
            req_b[i*WIDTH +: WIDTH] = cur[i].b;
            req_cin[i]              = cur[i].cin;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      resp_ready = hold_resp ? 1'b0 : (rnd_resp ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: grant checks, scoreboard push on accept, compare/pop on response.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        sb.delete();
        busy     = 1'b0;
        acc_mask = '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_gnt = NUM_REQ - 1;
`endif
      end else begin
        int                 g;
        logic [NUM_REQ-1:0] exp_rdy;
        logic               exp_v;
        exp_rdy = '0;
        if (!busy && req_valid != '0) begin
`ifdef ARB_ROUND_ROBIN_EN
          g = pick(req_valid, last_gnt);
`else
          g = pick(req_valid);
`endif
          exp_rdy[g] = 1'b1;
        end
        if (busy || req_valid != '0) check("req_ready", 64'(req_ready), 64'(exp_rdy));
        acc_mask = req_valid & req_ready;

        exp_v = busy && (cyc >= acc_cyc + ADD_LAT + 1);
        check("resp_valid", 64'(resp_valid), 64'(exp_v));
        if (resp_valid) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL resp_unexpected: got id %0d sum %0h with nothing outstanding", resp_id, resp_sum);
          end else begin
            check("resp_id", 64'(resp_id), 64'(sb[0].id));
            check("resp_sum", 64'(resp_sum), 64'(sb[0].sum));
            check("resp_carry", 64'(resp_carry), 64'(sb[0].carry));
            if (resp_ready) void'(sb.pop_front());
          end
          if (resp_ready) busy = 1'b0;
        end

        if (acc_mask != '0) begin
          int a_idx;
          a_idx = 0;
          for (int i = NUM_REQ - 1; i >= 0; i--) if (acc_mask[i]) a_idx = i;
          sb.push_back(model(a_idx, cur[a_idx]));
          busy    = 1'b1;
          acc_cyc = cyc;
`ifdef ARB_ROUND_ROBIN_EN
          last_gnt = a_idx;
`endif
        end
      end
    end
  end

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while ((pending() || sb.size() != 0 || busy || req_valid != '0) && n < LIMIT) begin
      @(posedge clock);
      n++;
    end
    check({"drain_", name}, 64'(n >= LIMIT), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clock);
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
    check({tag, "_resp_id"}, 64'(resp_id), 64'(0));
    check({tag, "_resp_sum"}, 64'(resp_sum), 64'(0));
    check({tag, "_resp_carry"}, 64'(resp_carry), 64'(0));
  endtask

  initial begin
    int unsigned n;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_reset_outputs("rst");

    pq[0].push_back(mk(32'd500, 32'd600, 1'b0));
    drain("single0");
    pq[1].push_back(mk(32'd1500, 32'd11600, 1'b1));
    drain("single1");
    pq[2].push_back(mk(32'hFFFF_FFFF, 32'd1, 1'b0));
    pq[3].push_back(mk(32'd50000, 32'd60020, 1'b0));
    drain("wrap");

    // All requesters contend with two operations each.
    for (int r = 0; r < NUM_REQ; r++) begin
      pq[r].push_back(mk(32'(1000 * (r + 1)), 32'(r), 1'b1));
      pq[r].push_back(mk(32'(7 + r), 32'hFFFF_FFF0, 1'b1));
    end
    drain("contend");

    // Backpressure: response held for ten cycles while another request waits.
    hold_resp = 1'b1;
    pq[0].push_back(mk(32'h1234_5678, 32'h1111_1111, 1'b0));
    pq[1].push_back(mk(32'd42, 32'd58, 1'b1));
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clock);
      n++;
    end
    check("bp_resp_seen", 64'(n >= 50), 64'(0));
    repeat (10) @(posedge clock);
    hold_resp = 1'b0;
    drain("backpressure");

    // Reset while the adder is busy discards the operation.
    pq[0].push_back(mk(32'd500, 32'd600, 1'b0));
    n = 0;
    while (!busy && n < 50) begin
      @(posedge clock);
      n++;
    end
    check("busy_seen", 64'(n >= 50), 64'(0));
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clock);
    pq[0].push_back(mk(32'd500, 32'd600, 1'b0));
    drain("after_reset");

    // Randomized traffic with random consumer stalls.
    rnd_resp = 1'b1;
    for (int k = 0; k < 150; k++) begin
      int r;
      r = $urandom_range(0, NUM_REQ - 1);
      pq[r].push_back(mk(rnd_word(), rnd_word(), 1'($urandom_range(0, 1))));
      repeat ($urandom_range(0, 4)) @(posedge clock);
    end
    drain("random");
    rnd_resp = 1'b0;

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
